// File: rtl/stream_demux_pkg.sv
// Shared types for the stream demultiplexer.
// Holds the per-channel occupancy state encoding.
package stream_demux_pkg;

   typedef enum logic {
      SLOT_EMPTY = 1'b0,
      SLOT_FULL  = 1'b1
   } slot_state_e;

endpackage

// File: rtl/stream_slot.sv
// One-entry valid/ready register for a single output channel.
// ready passes through rd_ready so a full slot can refill in the same cycle.
module stream_slot
   import stream_demux_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wr_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic             ready,
   output logic             rd_valid,
   input  logic             rd_ready,
   output logic [WIDTH-1:0] rd_data
);

   slot_state_e state;
   slot_state_e state_next;
   logic [WIDTH-1:0] data;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= SLOT_EMPTY;
         data  <= '0;
      end else begin
         state <= state_next;
         if (wr_en) begin
            data <= wr_data;
         end
      end
   end

   always_comb begin
      state_next = state;
      ready      = 1'b1;
      unique case (state)
         SLOT_EMPTY: begin
            if (wr_en) begin
               state_next = SLOT_FULL;
            end
         end
         SLOT_FULL: begin
            ready = rd_ready;
            if (rd_ready && !wr_en) begin
               state_next = SLOT_EMPTY;
            end
         end
         default: state_next = SLOT_EMPTY;
      endcase
   end

   assign rd_valid = (state == SLOT_FULL);
   assign rd_data  = data;

endmodule

// File: rtl/stream_demux.sv
// Routes one input stream to N_OUT independently buffered channels.
// A stalled channel only blocks words addressed to that channel.
module stream_demux
   import stream_demux_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int N_OUT = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [WIDTH-1:0]         in_data,
   input  logic [$clog2(N_OUT)-1:0] in_sel,
   output logic [N_OUT-1:0]         out_valid,
   input  logic [N_OUT-1:0]         out_ready,
   output logic [N_OUT*WIDTH-1:0]   out_data,
   output logic                     busy
);

   localparam int SEL_W = $clog2(N_OUT);

   logic [N_OUT-1:0] slot_ready;
   logic [N_OUT-1:0] wr_en;
   logic             accept;

   assign in_ready = slot_ready[in_sel];
   assign accept   = in_valid && in_ready;

   always_comb begin
      wr_en = '0;
      for (int k = 0; k < N_OUT; k++) begin
         wr_en[k] = accept && (in_sel == SEL_W'(k));
      end
   end

   for (genvar k = 0; k < N_OUT; k++) begin : g_slot
      stream_slot #(
         .WIDTH (WIDTH)
      ) u_slot (
         .clk      (clk),
         .rst_n    (rst_n),
         .wr_en    (wr_en[k]),
         .wr_data  (in_data),
         .ready    (slot_ready[k]),
         .rd_valid (out_valid[k]),
         .rd_ready (out_ready[k]),
         .rd_data  (out_data[k*WIDTH +: WIDTH])
      );
   end

   assign busy = |out_valid;

endmodule

// File: tb/tb_stream_demux.sv
// Directed and randomized checks of stream_demux against a
// per-channel queue model of the valid/ready contract.
module tb_stream_demux;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic [1:0]  in_sel;
   logic [3:0]  out_valid;
   logic [3:0]  out_ready;
   logic [31:0] out_data;
   logic        busy;

   int tests = 0;
   int fails = 0;
   int pushed = 0;
   int popped = 0;

   logic [7:0] q [4][$];

   stream_demux #(
      .WIDTH (8),
      .N_OUT (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drive(input logic v, input logic [1:0] s,
                        input logic [7:0] d, input logic [3:0] r);
      in_valid  = v;
      in_sel    = s;
      in_data   = d;
      out_ready = r;
      #1;
   endtask

   // One cycle checked against the queue model: a channel is full
   // exactly when its queue holds a word, and it shows the head.
   task automatic model_beat(input logic v, input logic [1:0] s,
                             input logic [7:0] d, input logic [3:0] r);
      logic       exp_rdy;
      logic [3:0] exp_valid;
      drive(v, s, d, r);
      exp_rdy = (q[s].size() == 0) || r[s];
      check("rand_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
      for (int k = 0; k < 4; k++) begin
         if (q[k].size() != 0) begin
            check($sformatf("rand_data_ch%0d", k),
                  {24'd0, out_data[k*8 +: 8]}, {24'd0, q[k][0]});
            if (r[k]) begin
               void'(q[k].pop_front());
               popped++;
            end
         end
      end
      if (v && exp_rdy) begin
         q[s].push_back(d);
         pushed++;
      end
      step();
      for (int k = 0; k < 4; k++) begin
         exp_valid[k] = (q[k].size() != 0);
      end
      check("rand_out_valid", {28'd0, out_valid}, {28'd0, exp_valid});
      check("rand_busy", {31'd0, busy}, {31'd0, |exp_valid});
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 2'd0, 8'h00, 4'h0);
      step();
      step();
      rst_n = 1'b1;
      check("reset_out_valid", {28'd0, out_valid}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_out_data", out_data, 32'd0);

      drive(1'b1, 2'd2, 8'hA5, 4'h0);
      check("first_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      drive(1'b0, 2'd0, 8'h00, 4'h0);
      check("first_out_valid", {28'd0, out_valid}, 32'h4);
      check("first_out_data", {24'd0, out_data[23:16]}, 32'hA5);
      check("first_busy", {31'd0, busy}, 32'd1);

      drive(1'b1, 2'd2, 8'hFF, 4'h0);
      for (int i = 0; i < 5; i++) begin
         check("blocked_in_ready", {31'd0, in_ready}, 32'd0);
         step();
         check("blocked_hold", {24'd0, out_data[23:16]}, 32'hA5);
         check("blocked_valid", {28'd0, out_valid}, 32'h4);
      end

      drive(1'b1, 2'd1, 8'h3C, 4'h0);
      check("bypass_in_ready", {31'd0, in_ready}, 32'd1);
      step();
      check("bypass_out_valid", {28'd0, out_valid}, 32'h6);
      check("bypass_data", {24'd0, out_data[15:8]}, 32'h3C);

      drive(1'b1, 2'd0, 8'h11, 4'h0);
      step();
      check("fill0_out_valid", {28'd0, out_valid}, 32'h7);
      drive(1'b1, 2'd0, 8'h22, 4'h1);
      check("swap_in_ready", {31'd0, in_ready}, 32'd1);
      check("swap_old_data", {24'd0, out_data[7:0]}, 32'h11);
      step();
      check("swap_out_valid", {28'd0, out_valid}, 32'h7);
      check("swap_new_data", {24'd0, out_data[7:0]}, 32'h22);

      drive(1'b0, 2'd0, 8'h00, 4'h5);
      step();
      check("drain_out_valid", {28'd0, out_valid}, 32'h2);
      drive(1'b1, 2'd3, 8'h77, 4'h0);
      step();
      check("pre_reset_valid", {28'd0, out_valid}, 32'hA);

      rst_n = 1'b0;
      drive(1'b1, 2'd0, 8'h99, 4'h0);
      step();
      rst_n = 1'b1;
      drive(1'b0, 2'd0, 8'h00, 4'h0);
      check("mid_reset_valid", {28'd0, out_valid}, 32'd0);
      check("mid_reset_busy", {31'd0, busy}, 32'd0);
      check("mid_reset_data", out_data, 32'd0);

      for (int i = 0; i < 1000; i++) begin
         model_beat(($urandom_range(0, 3) != 0),
                    2'($urandom_range(0, 3)),
                    8'($urandom),
                    4'($urandom));
      end
      for (int i = 0; i < 2; i++) begin
         model_beat(1'b0, 2'd0, 8'h00, 4'hF);
      end
      check("drained_valid", {28'd0, out_valid}, 32'd0);
      check("no_loss", popped, pushed);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/stream_demux.md
STREAM_DEMUX -- requirements
Module: stream_demux

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning the payload width in bits.
REQ-002 The block SHALL have parameter N_OUT, default 4, meaning the number of output channels; it is a power of two, at least 2.
REQ-003 The block SHALL derive localparam SEL_W = $clog2(N_OUT), meaning the channel-select width.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 Port in_valid, input, 1 bit: upstream offers a word this cycle.
REQ-007 Port in_ready, output, 1 bit: the block accepts the offered word this cycle.
REQ-008 Port in_data, input, WIDTH bits: the payload.
REQ-009 Port in_sel, input, SEL_W bits: the destination channel index.
REQ-010 Port out_valid, output, N_OUT bits: bit k means channel k holds a word.
REQ-011 Port out_ready, input, N_OUT bits: bit k means the channel k consumer takes the word.
REQ-012 Port out_data, output, N_OUT*WIDTH bits: the channel k payload sits in bits [k*WIDTH +: WIDTH].
REQ-013 Port busy, output, 1 bit: at least one channel holds a word.

Function
REQ-014 An input transfer SHALL occur exactly when in_valid and in_ready are both 1 on a rising clk edge; an output transfer on channel k SHALL occur exactly when out_valid[k] and out_ready[k] are both 1.
REQ-015 Each channel SHALL hold one registered entry with states EMPTY and FULL: EMPTY->FULL on an input transfer addressed to it; FULL->EMPTY on an output transfer with no new input transfer to it; FULL->FULL when an output transfer and an input transfer to it happen in the same cycle, with the data replaced.
REQ-016 in_ready SHALL be combinational: 1 when channel in_sel is EMPTY, or when it is FULL and out_ready[in_sel] is 1 in the same cycle; otherwise 0.
REQ-017 in_ready SHALL NOT depend on in_valid, and out_valid SHALL NOT depend on out_ready (no combinational valid-to-ready loops).
REQ-018 Latency SHALL be exactly 1 cycle: a word accepted at edge t appears on out_valid and out_data of its channel after edge t.
REQ-019 out_valid[k] SHALL equal the FULL state of channel k; out_data for channel k SHALL hold its entry and stay stable while FULL and not consumed.
REQ-020 A blocked channel SHALL NOT stall other channels: a word for an EMPTY channel is accepted even while another channel is FULL and not ready.
REQ-021 Ordering SHALL be preserved per channel; there is no ordering guarantee across channels.
REQ-022 A word SHALL never be dropped or duplicated; at most one input transfer SHALL occur per cycle.
REQ-023 busy SHALL equal the OR of out_valid.
REQ-024 in_data and in_sel SHALL be don't-care when in_valid is 0; no state changes.

Reset
REQ-025 While rst_n is 0 at a rising edge, every channel SHALL go to EMPTY; out_valid and busy SHALL be 0 from the next cycle.
REQ-026 out_data SHALL reset to 0.
REQ-027 Reset SHALL take priority over any simultaneous transfer: held words are discarded and no input transfer is recorded.
REQ-028 in_ready MAY be asserted during reset, but no transfer SHALL take effect.

Structure
REQ-029 One sub-module, stream_slot (a one-entry valid/ready register with WIDTH parameter and a pass-through ready), SHALL be instantiated N_OUT times in a generate loop.
REQ-030 The per-channel write enable SHALL be one-hot decoding of in_sel gated by in_valid and in_ready; in_ready SHALL be a mux of the slot ready signals indexed by in_sel.
REQ-031 No shared package is required; SEL_W stays local.

Verification
REQ-032 Reset, then in_sel=2, in_data=8'hA5, one beat with all out_ready=0 -> the next cycle out_valid=4'b0100, out_data[23:16]=8'hA5, busy=1.
REQ-033 Channel 2 FULL and out_ready[2]=0; offer sel=2 -> in_ready=0, and the held 8'hA5 is unchanged for 5 cycles.
REQ-034 Channel 2 FULL; offer sel=1, data 8'h3C -> in_ready=1, and the next cycle out_valid=4'b0110.
REQ-035 Channel 0 FULL with 8'h11, out_ready[0]=1, offer sel=0, data 8'h22 -> same-cycle transfer, out_valid[0] stays 1, out_data[7:0]=8'h22.
REQ-036 Channels 1 and 3 FULL, drive rst_n=0 for one cycle with in_valid=1 -> out_valid=0, busy=0, out_data all 0.
REQ-037 Send 1000 random beats with random sel and random out_ready -> per-channel scoreboard order matches, with no loss or duplication.
